// File: rtl/airlock_pkg.sv
// Shared types and encodings for the airlock sequencer.
// State set, door-select values and door status polarity.
package airlock_pkg;

  typedef enum logic [2:0] {
    IDLE_P,
    IDLE_D,
    PUMP_IN,
    PUMP_OUT,
    OPEN_WAIT,
    DOOR_OPEN,
    CLOSE_WAIT,
    FAULT
  } state_t;

  localparam logic SEL_INNER = 1'b0;
  localparam logic SEL_OUTER = 1'b1;

  localparam logic DOOR_CLOSED = 1'b1;

endpackage

// File: rtl/airlock_ctrl_timer.sv
// Loadable down-counter shared by pump phases and door timeouts.
// Saturates at zero; load has priority over the decrement.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/airlock_ctrl.sv
// Two-door airlock sequencer: pumping, door commands, interlock.
// Any door misbehaviour latches FAULT until reset.
module airlock_ctrl #(
  parameter int PUMP_CYCLES  = 8,
  parameter int DOOR_TIMEOUT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_inner,
  input  logic req_outer,
  input  logic pass_done,
  input  logic inner_status,
  input  logic outer_status,
  output logic inner_open,
  output logic inner_close,
  output logic outer_open,
  output logic outer_close,
  output logic pump_in,
  output logic pump_out,
  output logic pressurized,
  output logic busy,
  output logic fault
);

  import airlock_pkg::*;

  localparam int MAXC = (PUMP_CYCLES > DOOR_TIMEOUT)
                      ? PUMP_CYCLES : DOOR_TIMEOUT;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PUMP_LD = CW'(PUMP_CYCLES);
  localparam logic [CW-1:0] DOOR_LD = CW'(DOOR_TIMEOUT);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_t state, state_d;
  logic sel, sel_d;
  // {inner_open, inner_close, outer_open, outer_close}
  logic [3:0] cmd_d, cmd_q;

  logic          t_load;
  logic [CW-1:0] t_val;
  logic [CW-1:0] t_cnt;
  logic          t_zero;

  logic sel_st, oth_st, both_cl, door_ph;
  logic press_c, fault_p;

  cycle_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load),
    .value (t_val),
    .count (t_cnt),
    .zero  (t_zero)
  );

  assign sel_st  = sel ? outer_status : inner_status;
  assign oth_st  = sel ? inner_status : outer_status;
  assign both_cl = (inner_status == DOOR_CLOSED)
                && (outer_status == DOOR_CLOSED);
  assign door_ph = (state == OPEN_WAIT)
                || (state == DOOR_OPEN)
                || (state == CLOSE_WAIT);

  always_comb begin
    state_d = state;
    sel_d   = sel;
    cmd_d   = 4'b0000;
    t_load  = 1'b0;
    t_val   = DOOR_LD;
    unique case (state)
      IDLE_P: begin
        if (!both_cl) begin
          state_d = FAULT;
        end else if (req_inner) begin
          sel_d   = SEL_INNER;
          cmd_d   = 4'b1000;
          t_load  = 1'b1;
          state_d = OPEN_WAIT;
        end else if (req_outer) begin
          t_load  = 1'b1;
          t_val   = PUMP_LD;
          state_d = PUMP_OUT;
        end
      end
      IDLE_D: begin
        if (!both_cl) begin
          state_d = FAULT;
        end else if (req_outer) begin
          sel_d   = SEL_OUTER;
          cmd_d   = 4'b0010;
          t_load  = 1'b1;
          state_d = OPEN_WAIT;
        end else if (req_inner) begin
          t_load  = 1'b1;
          t_val   = PUMP_LD;
          state_d = PUMP_IN;
        end
      end
      PUMP_IN, PUMP_OUT: begin
        if (!both_cl) begin
          state_d = FAULT;
        end else if (t_cnt == ONE) begin
          state_d = (state == PUMP_IN) ? IDLE_P : IDLE_D;
        end
      end
      OPEN_WAIT: begin
        if (oth_st != DOOR_CLOSED) begin
          state_d = FAULT;
        end else if (sel_st != DOOR_CLOSED) begin
          state_d = DOOR_OPEN;
        end else if (t_zero) begin
          state_d = FAULT;
        end
      end
      DOOR_OPEN: begin
        if (oth_st != DOOR_CLOSED) begin
          state_d = FAULT;
        end else if (pass_done) begin
          cmd_d   = sel ? 4'b0001 : 4'b0100;
          t_load  = 1'b1;
          state_d = CLOSE_WAIT;
        end
      end
      CLOSE_WAIT: begin
        if (oth_st != DOOR_CLOSED) begin
          state_d = FAULT;
        end else if (sel_st == DOOR_CLOSED) begin
          state_d = sel ? IDLE_D : IDLE_P;
        end else if (t_zero) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE_P;
      sel     <= SEL_INNER;
      cmd_q   <= 4'b0000;
      fault_p <= 1'b1;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      cmd_q <= cmd_d;
      // remember chamber pressure at the moment FAULT is entered
      if (state != FAULT) begin
        fault_p <= press_c;
      end
    end
  end

  assign press_c = (state == IDLE_P)
                || (door_ph && (sel == SEL_INNER));

  assign {inner_open, inner_close,
          outer_open, outer_close} = cmd_q;

  assign pump_in     = (state == PUMP_IN);
  assign pump_out    = (state == PUMP_OUT);
  assign fault       = (state == FAULT);
  assign busy        = (state != IDLE_P) && (state != IDLE_D);
  assign pressurized = fault ? fault_p : press_c;

endmodule

// File: tb/tb_airlock_ctrl.sv
// Scoreboard bench for airlock_ctrl with behavioural door models.
// Expected output changes are queued with the cycle they must appear.
module tb_airlock_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_inner = 1'b0;
  logic req_outer = 1'b0;
  logic pass_done = 1'b0;
  logic inner_status, outer_status;
  logic inner_open, inner_close, outer_open, outer_close;
  logic pump_in, pump_out, pressurized, busy, fault;

  logic ign_i = 1'b0;
  logic force_o = 1'b0;
  logic ist, ost;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  localparam logic [8:0] IO = 9'h100;
  localparam logic [8:0] IC = 9'h080;
  localparam logic [8:0] OO = 9'h040;
  localparam logic [8:0] OC = 9'h020;
  localparam logic [8:0] PI = 9'h010;
  localparam logic [8:0] PO = 9'h008;
  localparam logic [8:0] PR = 9'h004;
  localparam logic [8:0] BU = 9'h002;
  localparam logic [8:0] FA = 9'h001;

  typedef struct {
    int         c;
    logic [8:0] v;
  } ev_t;

  ev_t q[$];
  logic [8:0] outv, prev;
  logic mon_en = 1'b0;

  airlock_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_inner    (req_inner),
    .req_outer    (req_outer),
    .pass_done    (pass_done),
    .inner_status (inner_status),
    .outer_status (outer_status),
    .inner_open   (inner_open),
    .inner_close  (inner_close),
    .outer_open   (outer_open),
    .outer_close  (outer_close),
    .pump_in      (pump_in),
    .pump_out     (pump_out),
    .pressurized  (pressurized),
    .busy         (busy),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // door models: latch commands on the edge after the pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ist <= 1'b1;
      ost <= 1'b1;
    end else begin
      if (inner_open && !ign_i) ist <= 1'b0;
      if (inner_close)          ist <= 1'b1;
      if (outer_open)           ost <= 1'b0;
      if (outer_close)          ost <= 1'b1;
    end
  end

  assign inner_status = ist;
  assign outer_status = ost & ~force_o;

  assign outv = {inner_open, inner_close, outer_open, outer_close,
                 pump_in, pump_out, pressurized, busy, fault};

  always @(negedge clk) begin
    if (mon_en && (outv !== prev)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b", cyc, outv);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (outv !== e.v || cyc != e.c) begin
          bad++;
          $display("FAIL event cyc=%0d got=%b want cyc=%0d %b",
                   cyc, outv, e.c, e.v);
        end
      end
      prev = outv;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int off, input logic [8:0] v);
    ev_t e;
    e.c = cyc + off;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [8:0] want);
    total++;
    if (outv !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, outv, want);
    end
  endtask

  task automatic close_door(input logic [8:0] cl, input logic [8:0] base,
                            input logic [8:0] idle);
    pass_done = 1'b1;
    expect_at(1, cl | base);
    expect_at(2, base);
    expect_at(3, idle);
    tick(1);
    pass_done = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_state", PR);
    tick(2);
    reset = 1'b0;
    ign_i = 1'b0;
    force_o = 1'b0;
    tick(2);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    check("reset_state", PR);
    tick(2);
    reset = 1'b0;
    prev = outv;
    mon_en = 1'b1;
    tick(2);

    // inner passage from IDLE_P, no pumping
    req_inner = 1'b1;
    expect_at(1, IO | PR | BU);
    expect_at(2, PR | BU);
    tick(1);
    req_inner = 1'b0;
    tick(2);
    close_door(IC, PR | BU, PR);

    // outer passage: 8 pump cycles then outer door
    req_outer = 1'b1;
    expect_at(1, PO | BU);
    expect_at(9, 9'h000);
    expect_at(10, OO | BU);
    expect_at(11, BU);
    tick(10);
    req_outer = 1'b0;
    tick(2);
    close_door(OC, BU, 9'h000);

    // both requests in IDLE_D: outer wins
    req_inner = 1'b1;
    req_outer = 1'b1;
    expect_at(1, OO | BU);
    expect_at(2, BU);
    tick(1);
    req_inner = 1'b0;
    req_outer = 1'b0;
    tick(2);
    close_door(OC, BU, 9'h000);

    // repressurize back to IDLE_P
    req_inner = 1'b1;
    expect_at(1, PI | BU);
    expect_at(9, PR);
    tick(1);
    req_inner = 1'b0;
    tick(11);

    // both requests in IDLE_P: inner wins
    req_inner = 1'b1;
    req_outer = 1'b1;
    expect_at(1, IO | PR | BU);
    expect_at(2, PR | BU);
    tick(1);
    req_inner = 1'b0;
    req_outer = 1'b0;
    tick(2);
    close_door(IC, PR | BU, PR);

    // inner door ignores open: timeout fault
    ign_i = 1'b1;
    req_inner = 1'b1;
    expect_at(1, IO | PR | BU);
    expect_at(2, PR | BU);
    expect_at(6, PR | BU | FA);
    tick(1);
    req_inner = 1'b0;
    tick(6);
    req_inner = 1'b1;
    req_outer = 1'b1;
    pass_done = 1'b1;
    tick(6);
    check("fault_sticky", PR | BU | FA);
    req_inner = 1'b0;
    req_outer = 1'b0;
    pass_done = 1'b0;
    expect_at(0, PR);
    do_reset();

    // outer door forced open while inner open
    req_inner = 1'b1;
    expect_at(1, IO | PR | BU);
    expect_at(2, PR | BU);
    tick(1);
    req_inner = 1'b0;
    tick(2);
    force_o = 1'b1;
    expect_at(1, PR | BU | FA);
    tick(3);
    expect_at(0, PR);
    do_reset();

    // reset in the middle of PUMP_IN
    req_outer = 1'b1;
    expect_at(1, PO | BU);
    expect_at(9, 9'h000);
    tick(1);
    req_outer = 1'b0;
    tick(10);
    req_inner = 1'b1;
    expect_at(1, PI | BU);
    tick(1);
    req_inner = 1'b0;
    tick(2);
    check("pump_in_active", PI | BU);
    #2;
    expect_at(0, PR);
    reset = 1'b1;
    #1;
    check("async_reset_pump", PR);
    tick(2);
    reset = 1'b0;
    tick(3);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_events left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
